tg_axi_master: RTL

//  AXI4-Lite initiator for the traffic-generator path. Accepts one register command (read or write)
//  on a valid/ready command port and runs exactly one AXI4-Lite transaction. Returns a single-cycle

---
 rtl/tg_axi_master.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/tg_axi_master.sv
// tg_axi_master: single-outstanding AXI4-Lite initiator for the traffic generator.
// Optional response watchdog with drain state: define TG_AXI_MASTER_TIMEOUT_EN.
module tg_axi_master #(
  parameter int AXI_ADDR_WIDTH = 32,
  parameter int AXI_DATA_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                        m_axi_aclk,
  input  logic                        m_axi_aresetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic                        cmd_rnw,
  input  logic [AXI_ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [AXI_DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [AXI_DATA_WIDTH/8-1:0] cmd_wstrb,
  output logic                        rsp_valid,
  output logic [AXI_DATA_WIDTH-1:0]   rsp_rdata,
  output logic [1:0]                  rsp_resp,
  output logic                        rsp_timeout,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [AXI_DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [AXI_DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [AXI_DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int SW = AXI_DATA_WIDTH / 8;

`ifdef TG_AXI_MASTER_TIMEOUT_EN
  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE, DRAIN
  } state_t;
`else
  typedef enum logic [2:0] {
    IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, DONE
  } state_t;
`endif

  state_t state, state_nxt;

  logic                      aw_done;
  logic                      w_done;
  logic [AXI_ADDR_WIDTH-1:0] addr_q;
  logic [AXI_DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]             wstrb_q;

  logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs;

  assign accept = cmd_valid && cmd_ready;
  assign aw_hs  = m_axi_awvalid && m_axi_awready;
  assign w_hs   = m_axi_wvalid && m_axi_wready;
  assign b_hs   = m_axi_bvalid && m_axi_bready;
  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && m_axi_rready;

  assign cmd_ready     = (state == IDLE);
  assign m_axi_awvalid = (state == WR_REQ) && !aw_done;
  assign m_axi_wvalid  = (state == WR_REQ) && !w_done;
  assign m_axi_arvalid = (state == RD_REQ);
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = wstrb_q;

`ifdef TG_AXI_MASTER_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;
  logic          is_rd;
  logic          in_resp;
  logic          to_fire;

  assign in_resp = (state == WR_RESP) || (state == RD_RESP);
  assign to_fire = in_resp && !b_hs && !r_hs &&
                   (cnt == CW'(TIMEOUT_CYCLES - 1));

  // a drained response still has to be consumed on its own channel
  assign m_axi_bready = (state == WR_RESP) ||
                        ((state == DRAIN) && !is_rd);
  assign m_axi_rready = (state == RD_RESP) ||
                        ((state == DRAIN) && is_rd);

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      cnt   <= '0;
      is_rd <= 1'b0;
    end else begin
      cnt <= in_resp ? cnt + 1'b1 : '0;
      if (accept) is_rd <= cmd_rnw;
    end
  end
`else
  assign m_axi_bready = (state == WR_RESP);
  assign m_axi_rready = (state == RD_RESP);
  assign rsp_timeout  = 1'b0;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
  end
`endif

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) state <= IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:
        if (accept) state_nxt = cmd_rnw ? RD_REQ : WR_REQ;
      WR_REQ:
        if ((aw_done || aw_hs) && (w_done || w_hs))
          state_nxt = WR_RESP;
      WR_RESP: begin
        if (b_hs) state_nxt = DONE;
`ifdef TG_AXI_MASTER_TIMEOUT_EN
        else if (to_fire) state_nxt = DRAIN;
`endif
      end
      RD_REQ:
        if (ar_hs) state_nxt = RD_RESP;
      RD_RESP: begin
        if (r_hs) state_nxt = DONE;
`ifdef TG_AXI_MASTER_TIMEOUT_EN
        else if (to_fire) state_nxt = DRAIN;
`endif
      end
      DONE:
        state_nxt = IDLE;
`ifdef TG_AXI_MASTER_TIMEOUT_EN
      DRAIN:
        if (b_hs || r_hs) state_nxt = IDLE;
`endif
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge m_axi_aclk) begin
    if (!m_axi_aresetn) begin
      aw_done   <= 1'b0;
      w_done    <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_resp  <= '0;
`ifdef TG_AXI_MASTER_TIMEOUT_EN
      rsp_timeout <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (accept) begin
        addr_q  <= cmd_addr;
        wdata_q <= cmd_wdata;
        wstrb_q <= cmd_wstrb;
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end
      if (aw_hs) aw_done <= 1'b1;
      if (w_hs)  w_done  <= 1'b1;
      if ((state == WR_RESP) && b_hs) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= '0;
        rsp_resp  <= m_axi_bresp;
`ifdef TG_AXI_MASTER_TIMEOUT_EN
        rsp_timeout <= 1'b0;
`endif
      end
      if ((state == RD_RESP) && r_hs) begin
        rsp_valid <= 1'b1;
        rsp_rdata <= m_axi_rdata;
        rsp_resp  <= m_axi_rresp;
`ifdef TG_AXI_MASTER_TIMEOUT_EN
        rsp_timeout <= 1'b0;
`endif
      end
`ifdef TG_AXI_MASTER_TIMEOUT_EN
      if (to_fire) begin
        rsp_valid   <= 1'b1;
        rsp_rdata   <= '0;
        rsp_resp    <= 2'b10;
        rsp_timeout <= 1'b1;
      end
`endif
    end
  end

endmodule
